// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul control block: sequencer state encoding,
// APB register addresses and register bit positions.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_e;

  localparam logic [15:0] CTRL_ADDR   = 16'h0000;
  localparam logic [15:0] STATUS_ADDR = 16'h0008;

  // CTRL fields
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_N_LSB     = 4;
  localparam int unsigned CTRL_K_LSB     = 8;
  localparam int unsigned CTRL_M_LSB     = 12;

  // STATUS fields
  localparam int unsigned STAT_BUSY_BIT = 1'b0;
  localparam int unsigned STAT_DONE_BIT = 1;
  localparam int unsigned STAT_CNT_LSB  = 8;
  localparam int unsigned CNT_W         = 8;

endpackage

// File: rtl/matmul_apb_regs.sv
// APB register slave for the matmul control block.
// Decodes CTRL/STATUS, answers with zero wait states, latches the matrix
// dimensions, and holds the sticky done flag (write-1-to-clear).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   psel_i/penable_i/pwrite_i    APB control
//   pstrb_i, pwdata_i, paddr_i   APB write strobe, data, address
//   pready_o/pslverr_o/prdata_o  APB response (zero outside access phase)
//   busy_i                       sequencer busy (blocks CTRL writes)
//   done_set_i                   sequencer is in its completion cycle
//   cycle_cnt_i                  busy-cycle count for STATUS readback
//   start_pulse_o                accepted START write, one cycle
//   n_dim_o/k_dim_o/m_dim_o      latched dimensions minus one
module matmul_apb_regs
  import matmul_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_DIM    = 4,
  parameter int unsigned DIM_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [MAX_DIM-1:0]    pstrb_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  input  logic                  busy_i,
  input  logic                  done_set_i,
  input  logic [CNT_W-1:0]      cycle_cnt_i,
  output logic                  start_pulse_o,
  output logic [DIM_W-1:0]      n_dim_o,
  output logic [DIM_W-1:0]      k_dim_o,
  output logic [DIM_W-1:0]      m_dim_o
);

  logic access, ctrl_hit, stat_hit, lane0_wr, ctrl_wr_ok, done_clr;
  logic [DIM_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d;
  logic done_q, done_d;

  // Only lane 0 carries register bits; the remaining data/strobe bits are
  // accepted on the bus but have no destination.
  logic unused_bits;
  assign unused_bits = ^{pwdata_i, pstrb_i};

  assign access   = psel_i & penable_i;
  assign ctrl_hit = (paddr_i == ADDR_WIDTH'(CTRL_ADDR));
  assign stat_hit = (paddr_i == ADDR_WIDTH'(STATUS_ADDR));
  assign lane0_wr = access & pwrite_i & pstrb_i[0];

  // A strobe-less write is a silent no-op, so the busy error only applies
  // to writes that would actually have modified CTRL.
  assign ctrl_wr_ok    = lane0_wr & ctrl_hit & ~busy_i;
  assign start_pulse_o = ctrl_wr_ok & pwdata_i[CTRL_START_BIT];
  assign done_clr      = lane0_wr & stat_hit & pwdata_i[STAT_DONE_BIT];

  assign pready_o  = access;
  assign pslverr_o = access & (~(ctrl_hit | stat_hit) | (lane0_wr & ctrl_hit & busy_i));

  always_comb begin
    prdata_o = '0;
    if (access && !pwrite_i) begin
      if (ctrl_hit) begin
        prdata_o[CTRL_N_LSB +: DIM_W] = n_q;
        prdata_o[CTRL_K_LSB +: DIM_W] = k_q;
        prdata_o[CTRL_M_LSB +: DIM_W] = m_q;
      end else if (stat_hit) begin
        prdata_o[STAT_BUSY_BIT]         = busy_i;
        prdata_o[STAT_DONE_BIT]         = done_q;
        prdata_o[STAT_CNT_LSB +: CNT_W] = cycle_cnt_i;
      end
    end
  end

  always_comb begin
    n_d    = n_q;
    k_d    = k_q;
    m_d    = m_q;
    done_d = done_q;
    if (ctrl_wr_ok) begin
      n_d = pwdata_i[CTRL_N_LSB +: DIM_W];
      k_d = pwdata_i[CTRL_K_LSB +: DIM_W];
      m_d = pwdata_i[CTRL_M_LSB +: DIM_W];
    end
    if (start_pulse_o || done_clr) done_d = 1'b0;
    // Completion beats a coincident clear so the event is never lost.
    if (done_set_i) done_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q    <= '0;
      k_q    <= '0;
      m_q    <= '0;
      done_q <= 1'b0;
    end else begin
      n_q    <= n_d;
      k_q    <= k_d;
      m_q    <= m_d;
      done_q <= done_d;
    end
  end

  assign n_dim_o = n_q;
  assign k_dim_o = k_q;
  assign m_dim_o = m_q;

endmodule

// File: rtl/matmul_ctrl.sv
// Control/sequencing block for the matmul systolic array.
// Accepts START through the APB register slave, then steps the array
// through CLEAR -> FEED -> DRAIN -> WB -> DONE while asserting busy.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   psel..paddr                APB request (psel pre-decoded for this block)
//   pready, pslverr, prdata    APB response
//   busy                       operation in progress
//   sa_clear, sa_step          array accumulator clear / step enable
//   feed_step                  feed step index for operand skew
//   n_dim, k_dim, m_dim        latched dimensions minus one
//   wb_valid, wb_row, wb_ready result row write-back handshake
//   done_irq                   one-cycle completion pulse
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned BUS_WIDTH  = 64,
  parameter  int unsigned ADDR_WIDTH = 16,
  localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int unsigned DIM_W      = $clog2(MAX_DIM),
  localparam int unsigned STEP_W     = $clog2(3 * MAX_DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [MAX_DIM-1:0]    pstrb,
  input  logic [BUS_WIDTH-1:0]  pwdata,
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pready,
  output logic                  pslverr,
  output logic [BUS_WIDTH-1:0]  prdata,
  output logic                  busy,
  output logic                  sa_clear,
  output logic                  sa_step,
  output logic [STEP_W-1:0]     feed_step,
  output logic [DIM_W-1:0]      n_dim,
  output logic [DIM_W-1:0]      k_dim,
  output logic [DIM_W-1:0]      m_dim,
  output logic                  wb_valid,
  output logic [DIM_W-1:0]      wb_row,
  input  logic                  wb_ready,
  output logic                  done_irq
);

  ctrl_state_e       state_q;
  logic              busy_q, sa_clear_q, sa_step_q, wb_valid_q, done_irq_q;
  logic [STEP_W-1:0] feed_step_q, last_step;
  logic [DIM_W-1:0]  wb_row_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_pulse;
  logic [DIM_W-1:0]  n_w, k_w, m_w;

  matmul_apb_regs #(
    .BUS_WIDTH  (BUS_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_DIM    (MAX_DIM),
    .DIM_W      (DIM_W)
  ) u_regs (
    .clk_i         (clk),
    .rst_i         (rst),
    .psel_i        (psel),
    .penable_i     (penable),
    .pwrite_i      (pwrite),
    .pstrb_i       (pstrb),
    .pwdata_i      (pwdata),
    .paddr_i       (paddr),
    .pready_o      (pready),
    .pslverr_o     (pslverr),
    .prdata_o      (prdata),
    .busy_i        (busy_q),
    .done_set_i    (done_irq_q),
    .cycle_cnt_i   (cnt_q),
    .start_pulse_o (start_pulse),
    .n_dim_o       (n_w),
    .k_dim_o       (k_w),
    .m_dim_o       (m_w)
  );

  // Feed lasts (N-1)+(K-1)+(M-1)+1 cycles, so the final index is the plain
  // sum of the stored minus-one fields.
  assign last_step = STEP_W'(n_w) + STEP_W'(k_w) + STEP_W'(m_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      sa_clear_q  <= 1'b0;
      sa_step_q   <= 1'b0;
      feed_step_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_row_q    <= '0;
      done_irq_q  <= 1'b0;
    end else begin
      sa_clear_q <= 1'b0;
      done_irq_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_pulse) begin
            state_q    <= ST_CLEAR;
            busy_q     <= 1'b1;
            sa_clear_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q     <= ST_FEED;
          sa_step_q   <= 1'b1;
          feed_step_q <= '0;
        end
        ST_FEED: begin
          if (feed_step_q == last_step) begin
            state_q     <= ST_DRAIN;
            feed_step_q <= '0;
          end else begin
            feed_step_q <= feed_step_q + STEP_W'(1);
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_WB;
          sa_step_q  <= 1'b0;
          wb_valid_q <= 1'b1;
          wb_row_q   <= '0;
        end
        ST_WB: begin
          if (wb_ready) begin
            if (wb_row_q == n_w) begin
              state_q    <= ST_DONE;
              wb_valid_q <= 1'b0;
              wb_row_q   <= '0;
              done_irq_q <= 1'b1;
            end else begin
              wb_row_q <= wb_row_q + DIM_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          sa_step_q  <= 1'b0;
          wb_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Busy-cycle counter: restarts on START, counts every busy cycle, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (start_pulse) cnt_d = '0;
    else if (busy_q && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy      = busy_q;
  assign sa_clear  = sa_clear_q;
  assign sa_step   = sa_step_q;
  assign feed_step = feed_step_q;
  assign wb_valid  = wb_valid_q;
  assign wb_row    = wb_row_q;
  assign done_irq  = done_irq_q;
  assign n_dim     = n_w;
  assign k_dim     = k_w;
  assign m_dim     = m_w;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl.
module tb_matmul_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [63:0] pwdata;
  logic [15:0] paddr;
  logic        pready, pslverr;
  logic [63:0] prdata;
  logic        busy, sa_clear, sa_step;
  logic [3:0]  feed_step;
  logic [1:0]  n_dim, k_dim, m_dim;
  logic        wb_valid;
  logic [1:0]  wb_row;
  logic        wb_ready;
  logic        done_irq;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  matmul_ctrl #(
    .DATA_WIDTH (16),
    .BUS_WIDTH  (64),
    .ADDR_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pstrb     (pstrb),
    .pwdata    (pwdata),
    .paddr     (paddr),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata),
    .busy      (busy),
    .sa_clear  (sa_clear),
    .sa_step   (sa_step),
    .feed_step (feed_step),
    .n_dim     (n_dim),
    .k_dim     (k_dim),
    .m_dim     (m_dim),
    .wb_valid  (wb_valid),
    .wb_row    (wb_row),
    .wb_ready  (wb_ready),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic apb_write(input logic [15:0] a, input logic [63:0] d,
                           input logic [3:0] s, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    err = pslverr;
    check("pready_wr", pready, 1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [63:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pstrb = '0;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    d   = prdata;
    err = pslverr;
    check("pready_rd", pready, 1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Starts an operation and follows it to completion. Expected feed steps
  // and write-back rows are queued up front and popped as the DUT shows them.
  // Optionally stalls wb_ready at one row, and optionally issues one extra
  // APB write whose setup phase falls on loop cycle apb_at.
  task automatic run_op(input string nm, input logic [15:0] ctrl,
                        input int stall_row, input int stall_n,
                        input int apb_at, input logic [15:0] apb_a,
                        input logic [63:0] apb_d, input logic exp_err,
                        input logic exp_irq);
    int n, k, m, s, exp_busy, e, stall_left;
    int busy_n = 0, clr_n = 0, irq_n = 0, step_n = 0;
    int fq[$];
    int rq[$];
    logic err;
    logic coll_err = 1'b0;
    n = int'(ctrl[5:4]) + 1;
    k = int'(ctrl[9:8]) + 1;
    m = int'(ctrl[13:12]) + 1;
    s = (n - 1) + (k - 1) + (m - 1) + 1;
    exp_busy = 1 + s + 1 + n + stall_n + 1;
    for (int i = 0; i < s; i++) fq.push_back(i);
    for (int i = 0; i < n; i++) rq.push_back(i);
    stall_left = stall_n;
    wb_ready = 1'b1;
    apb_write(16'h0000, {48'd0, ctrl}, 4'hF, err);
    check({nm, "_start_err"}, err, 0);
    for (int c = 0; c < 300; c++) begin
      if (!busy) break;
      if (c == 0) check({nm, "_clear_first"}, sa_clear, 1);
      busy_n++;
      if (sa_clear) clr_n++;
      if (done_irq) irq_n++;
      if (sa_step) begin
        step_n++;
        if (fq.size() > 0) begin
          e = fq.pop_front();
          check({nm, "_feed_step"}, feed_step, e);
        end
      end
      if (wb_valid && int'(wb_row) == stall_row && stall_left > 0) begin
        wb_ready = 1'b0;
        stall_left--;
      end else begin
        wb_ready = 1'b1;
      end
      if (wb_valid && wb_ready) begin
        if (rq.size() > 0) e = rq.pop_front();
        else e = 99;
        check({nm, "_wb_row"}, wb_row, e);
      end
      if (apb_at >= 0 && c == apb_at) begin
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
        paddr = apb_a; pwdata = apb_d; pstrb = '1;
      end
      if (apb_at >= 0 && c == apb_at + 1) begin
        check({nm, "_irq_at_access"}, done_irq, exp_irq);
        penable = 1'b1;
        #1;
        coll_err = pslverr;
      end
      if (apb_at >= 0 && c == apb_at + 2) begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
    wb_ready = 1'b1;
    check({nm, "_ends"}, busy, 0);
    check({nm, "_busy_cycles"}, busy_n, exp_busy);
    check({nm, "_clear_cnt"}, clr_n, 1);
    check({nm, "_irq_cnt"}, irq_n, 1);
    check({nm, "_step_cnt"}, step_n, s + 1);
    check({nm, "_feed_left"}, fq.size(), 0);
    check({nm, "_rows_left"}, rq.size(), 0);
    if (apb_at >= 0) check({nm, "_apb_err"}, coll_err, exp_err);
  endtask

  initial begin
    logic [63:0] rd;
    logic        err;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pstrb = '0; pwdata = '0; paddr = '0; wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_sa_step", sa_step, 0);
    check("rst_sa_clear", sa_clear, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_done_irq", done_irq, 0);
    check("rst_pready_idle", pready, 0);
    check("rst_dims", {n_dim, k_dim, m_dim}, 0);
    apb_read(16'h0008, rd, err);
    check("rst_status", rd, 64'h0);

    // 2x2x2 basic run
    run_op("op222", 16'h1111, -1, 0, -1, 16'h0, 64'h0, 1'b0, 1'b0);
    check("op222_dims", {n_dim, k_dim, m_dim}, 6'b01_01_01);
    apb_read(16'h0008, rd, err);
    check("op222_status", rd, 64'h0902);
    apb_read(16'h0000, rd, err);
    check("ctrl_readback", rd, 64'h1110);

    // W1C of done after completion
    apb_write(16'h0008, 64'h2, 4'h1, err);
    check("w1c_err", err, 0);
    apb_read(16'h0008, rd, err);
    check("w1c_status", rd, 64'h0900);

    // 4x4x4 run
    run_op("op444", 16'h3331, -1, 0, -1, 16'h0, 64'h0, 1'b0, 1'b0);
    apb_read(16'h0008, rd, err);
    check("op444_status", rd, 64'h1102);

    // 4x4x4 with write-back stalled 3 cycles at row 1
    run_op("op444_stall", 16'h3331, 1, 3, -1, 16'h0, 64'h0, 1'b0, 1'b0);
    apb_read(16'h0008, rd, err);
    check("stall_status", rd, 64'h1402);

    // CTRL START while busy: error, timing and dims unaffected
    run_op("busy_wr", 16'h1111, -1, 0, 2, 16'h0000, 64'h3331, 1'b1, 1'b0);
    check("busy_wr_dims", {n_dim, k_dim, m_dim}, 6'b01_01_01);
    apb_read(16'h0008, rd, err);
    check("busy_wr_status", rd, 64'h0902);

    // Unmapped address
    apb_read(16'h0010, rd, err);
    check("bad_addr_err", err, 1);
    check("bad_addr_data", rd, 64'h0);

    // Strobe-less CTRL write: ignored, no error
    apb_write(16'h0000, 64'h3331, 4'b1110, err);
    check("nostrb_err", err, 0);
    check("nostrb_busy", busy, 0);
    check("nostrb_dims", {n_dim, k_dim, m_dim}, 6'b01_01_01);

    // W1C landing in the DONE cycle: set wins
    run_op("w1c_race", 16'h1111, -1, 0, 7, 16'h0008, 64'h2, 1'b0, 1'b1);
    apb_read(16'h0008, rd, err);
    check("w1c_race_status", rd, 64'h0902);

    // Reset in the middle of FEED
    apb_write(16'h0000, 64'h3331, 4'hF, err);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_feeding", sa_step, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_sa_step", sa_step, 0);
    check("midrst_feed_step", feed_step, 0);
    check("midrst_dims", {n_dim, k_dim, m_dim}, 0);
    apb_read(16'h0008, rd, err);
    check("midrst_status", rd, 64'h0);

    run_op("post_rst", 16'h1111, -1, 0, -1, 16'h0, 64'h0, 1'b0, 1'b0);
    apb_read(16'h0008, rd, err);
    check("post_rst_status", rd, 64'h0902);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
